// File: rtl/dcache_ctrl_if.sv
// rtl/dcache_ctrl_if.sv - MEM-stage load/store and line-wide memory signals of dcache_ctrl
// slave is the cache controller side; master is the pipeline/memory side.
interface dcache_ctrl_if;
   logic         cpu_req_i;
   logic         cpu_we_i;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_data_i;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;
   logic         mem_req_o;
   logic         mem_we_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i;
   logic         mem_ack_i;

   modport slave (
      input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
      output cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
   );

   modport master (
      output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
      input  cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
   );
endinterface

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate data cache controller
// Defining DCACHE_STATS_EN adds the hit_cnt_o / miss_cnt_o counters.
module dcache_ctrl #(
   parameter int NUM_LINES  = 16,
   parameter int LINE_BYTES = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
`ifdef DCACHE_STATS_EN
   output logic [31:0]  hit_cnt_o,
   output logic [31:0]  miss_cnt_o,
`endif
   dcache_ctrl_if.slave bus
);
   localparam int IDX_W  = $clog2(NUM_LINES);
   localparam int TAG_W  = 32 - 5 - IDX_W;
   localparam int LINE_W = LINE_BYTES * 8;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_WB      = 2'd1;
   localparam logic [1:0] S_FILL    = 2'd2;
   localparam logic [1:0] S_INSTALL = 2'd3;

   logic [1:0]           r_state;
   logic [NUM_LINES-1:0] r_valid;
   logic [NUM_LINES-1:0] r_dirty;
   logic [TAG_W-1:0]     r_tag  [NUM_LINES];
   logic [LINE_W-1:0]    r_data [NUM_LINES];
   logic [TAG_W-1:0]     r_miss_tag;
   logic [IDX_W-1:0]     r_miss_idx;
   logic [LINE_W-1:0]    r_fill;
   logic                 r_mem_req;
   logic                 r_mem_we;
   logic [31:0]          r_mem_addr;
   logic [LINE_W-1:0]    r_mem_data;

   logic [2:0]           w_word;
   logic [7:0]           w_bit;
   logic [IDX_W-1:0]     w_idx;
   logic [TAG_W-1:0]     w_tag;
   logic                 w_hit;
   logic                 w_miss;
   logic                 w_ack;
   logic                 w_unused;

   assign w_word   = bus.cpu_addr_i[4:2];
   assign w_bit    = {w_word, 5'b00000};
   assign w_idx    = bus.cpu_addr_i[5+IDX_W-1:5];
   assign w_tag    = bus.cpu_addr_i[31:5+IDX_W];
   assign w_unused = ^bus.cpu_addr_i[1:0];

   assign w_hit  = bus.cpu_req_i & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
   assign w_miss = (r_state == S_IDLE) & bus.cpu_req_i & ~w_hit;
   // An ack arriving with no request outstanding is dropped here.
   assign w_ack  = bus.mem_ack_i & r_mem_req;

   assign bus.cpu_stall_o = (r_state != S_IDLE) | (bus.cpu_req_i & ~w_hit);
   assign bus.cpu_data_o  = w_hit ? r_data[w_idx][w_bit +: 32] : 32'd0;
   assign bus.mem_req_o   = r_mem_req;
   assign bus.mem_we_o    = r_mem_we;
   assign bus.mem_addr_o  = r_mem_addr;
   assign bus.mem_data_o  = r_mem_data;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= S_IDLE;
         r_valid    <= '0;
         r_dirty    <= '0;
         r_miss_tag <= '0;
         r_miss_idx <= '0;
         r_fill     <= '0;
         r_mem_req  <= 1'b0;
         r_mem_we   <= 1'b0;
         r_mem_addr <= 32'd0;
         r_mem_data <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_hit && bus.cpu_we_i) begin
                  r_dirty[w_idx] <= 1'b1;
               end else if (w_miss) begin
                  r_miss_tag <= w_tag;
                  r_miss_idx <= w_idx;
                  r_mem_req  <= 1'b1;
                  if (r_valid[w_idx] && r_dirty[w_idx]) begin
                     r_state    <= S_WB;
                     r_mem_we   <= 1'b1;
                     r_mem_addr <= {r_tag[w_idx], w_idx, 5'b00000};
                     r_mem_data <= r_data[w_idx];
                  end else begin
                     r_state    <= S_FILL;
                     r_mem_we   <= 1'b0;
                     r_mem_addr <= {w_tag, w_idx, 5'b00000};
                  end
               end
            end
            S_WB: begin
               // Keep the request up and retarget it straight at the fill.
               if (w_ack) begin
                  r_state    <= S_FILL;
                  r_mem_we   <= 1'b0;
                  r_mem_addr <= {r_miss_tag, r_miss_idx, 5'b00000};
               end
            end
            S_FILL: begin
               if (w_ack) begin
                  r_fill    <= bus.mem_data_i;
                  r_mem_req <= 1'b0;
                  r_state   <= S_INSTALL;
               end
            end
            default: begin
               r_valid[r_miss_idx] <= 1'b1;
               r_dirty[r_miss_idx] <= 1'b0;
               r_state             <= S_IDLE;
            end
         endcase
      end
   end

   // Tag and data storage carry no reset; the valid bits gate them.
   always_ff @(posedge clk_i) begin
      if (r_state == S_INSTALL) begin
         r_data[r_miss_idx] <= r_fill;
         r_tag[r_miss_idx]  <= r_miss_tag;
      end else if (r_state == S_IDLE && w_hit && bus.cpu_we_i) begin
         r_data[w_idx][w_bit +: 32] <= bus.cpu_data_i;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_hit_cnt  <= 32'd0;
         r_miss_cnt <= 32'd0;
      end else begin
         if (r_state == S_IDLE && w_hit) r_hit_cnt <= r_hit_cnt + 32'd1;
         if (w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
      end
   end

   assign hit_cnt_o  = r_hit_cnt;
   assign miss_cnt_o = r_miss_cnt;
`endif
endmodule
